// File: rtl/uart_apb_ctrl.sv
// uart_apb_ctrl: APB master that configures a UART core and then moves bytes.
// It writes the baud/mode registers once after reset, then arbitrates between
// reading received bytes and writing bytes to transmit. After every access it
// waits GUARD idle cycles so the core status flags reflect that access.
module uart_apb_ctrl #(
  parameter logic [12:0] BAUD_VALUE = 13'd1,
  parameter logic [2:0]  MODE       = 3'b001,
  parameter int unsigned GUARD      = 2
) (
  input  logic       PCLK,
  input  logic       PRESETN,
  output logic [4:0] PADDR,
  output logic       PSEL,
  output logic       PENABLE,
  output logic       PWRITE,
  output logic [7:0] PWDATA,
  input  logic [7:0] PRDATA,
  input  logic       PREADY,
  input  logic       PSLVERR,
  input  logic       TXRDY,
  input  logic       RXRDY,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       cfg_done,
  output logic       err_slv,
  input  logic       err_clr
);

  typedef enum logic [2:0] {
    INIT1,
    INIT2,
    IDLE,
    SETUP,
    ACCESS,
    HOLD
  } state_e;

  // Which access is in flight, so completion and the end of HOLD know what to do.
  typedef enum logic [1:0] {
    K_INIT1,
    K_INIT2,
    K_TX,
    K_RX
  } kind_e;

  localparam logic [4:0] ADDR_TX    = 5'h00;
  localparam logic [4:0] ADDR_RX    = 5'h04;
  localparam logic [4:0] ADDR_CTRL1 = 5'h08;
  localparam logic [4:0] ADDR_CTRL2 = 5'h0C;
  localparam logic [2:0] HOLD_LAST  = 3'(GUARD - 1);

  state_e     state_q, state_d;
  kind_e      kind_q, kind_d;
  logic [2:0] holdCnt_q, holdCnt_d;
  logic [4:0] paddr_q, paddr_d;
  logic       pwrite_q, pwrite_d;
  logic [7:0] pwdata_q, pwdata_d;
  logic [7:0] rxData_q, rxData_d;
  logic       rxValid_q, rxValid_d;
  logic       cfgDone_q, cfgDone_d;
  logic       errSlv_q, errSlv_d;
  logic       rxWin, txWin;

  // A read wins over a write, and a new read waits until the held byte is taken.
  assign rxWin = RXRDY && !rxValid_q;
  assign txWin = tx_valid && TXRDY;

  // Next-state logic: sequence the init writes, arbitrate, and run the APB handshake.
  always_comb begin
    state_d   = state_q;
    kind_d    = kind_q;
    holdCnt_d = holdCnt_q;
    paddr_d   = paddr_q;
    pwrite_d  = pwrite_q;
    pwdata_d  = pwdata_q;
    rxData_d  = rxData_q;
    rxValid_d = rxValid_q;
    cfgDone_d = cfgDone_q;
    errSlv_d  = errSlv_q;
    tx_ready  = 1'b0;

    if (rxValid_q && rx_ready) begin
      rxValid_d = 1'b0;
    end
    if (err_clr) begin
      errSlv_d = 1'b0;
    end

    case (state_q)
      INIT1: begin
        paddr_d  = ADDR_CTRL1;
        pwrite_d = 1'b1;
        pwdata_d = BAUD_VALUE[7:0];
        kind_d   = K_INIT1;
        state_d  = SETUP;
      end
      INIT2: begin
        paddr_d  = ADDR_CTRL2;
        pwrite_d = 1'b1;
        pwdata_d = {BAUD_VALUE[12:8], MODE};
        kind_d   = K_INIT2;
        state_d  = SETUP;
      end
      IDLE: begin
        if (rxWin) begin
          paddr_d  = ADDR_RX;
          pwrite_d = 1'b0;
          kind_d   = K_RX;
          state_d  = SETUP;
        end else if (txWin) begin
          tx_ready = 1'b1;
          paddr_d  = ADDR_TX;
          pwrite_d = 1'b1;
          pwdata_d = tx_data;
          kind_d   = K_TX;
          state_d  = SETUP;
        end
      end
      SETUP: begin
        state_d = ACCESS;
      end
      ACCESS: begin
        if (PREADY) begin
          if (PSLVERR) begin
            errSlv_d = 1'b1;
          end
          if (kind_q == K_RX) begin
            rxData_d  = PRDATA;
            rxValid_d = 1'b1;
          end
          if (kind_q == K_INIT2) begin
            cfgDone_d = 1'b1;
          end
          holdCnt_d = 3'd0;
          state_d   = HOLD;
        end
      end
      HOLD: begin
        if (holdCnt_q == HOLD_LAST) begin
          state_d = (kind_q == K_INIT1) ? INIT2 : IDLE;
        end else begin
          holdCnt_d = holdCnt_q + 3'd1;
        end
      end
      default: begin
        state_d = INIT1;
      end
    endcase
  end

  // State and output registers; reset aborts any access and restarts init.
  always_ff @(posedge PCLK or negedge PRESETN) begin
    if (!PRESETN) begin
      state_q   <= INIT1;
      kind_q    <= K_INIT1;
      holdCnt_q <= 3'd0;
      paddr_q   <= 5'd0;
      pwrite_q  <= 1'b0;
      pwdata_q  <= 8'd0;
      rxData_q  <= 8'd0;
      rxValid_q <= 1'b0;
      cfgDone_q <= 1'b0;
      errSlv_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      kind_q    <= kind_d;
      holdCnt_q <= holdCnt_d;
      paddr_q   <= paddr_d;
      pwrite_q  <= pwrite_d;
      pwdata_q  <= pwdata_d;
      rxData_q  <= rxData_d;
      rxValid_q <= rxValid_d;
      cfgDone_q <= cfgDone_d;
      errSlv_q  <= errSlv_d;
    end
  end

  assign PSEL     = (state_q == SETUP) || (state_q == ACCESS);
  assign PENABLE  = (state_q == ACCESS);
  assign PADDR    = paddr_q;
  assign PWRITE   = pwrite_q;
  assign PWDATA   = pwdata_q;
  assign rx_data  = rxData_q;
  assign rx_valid = rxValid_q;
  assign cfg_done = cfgDone_q;
  assign err_slv  = errSlv_q;

endmodule

// File: tb/tb_uart_apb_ctrl.sv
// tb_uart_apb_ctrl: drives uart_apb_ctrl against a simple APB completer model
// and checks init, TX/RX arbitration, backpressure, wait states, errors, reset.
module tb_uart_apb_ctrl;

  localparam int GUARD_P = 2;

  logic       PCLK = 1'b0;
  logic       PRESETN;
  logic [4:0] PADDR;
  logic       PSEL, PENABLE, PWRITE;
  logic [7:0] PWDATA;
  logic [7:0] PRDATA = 8'h00;
  logic       PREADY = 1'b0;
  logic       PSLVERR = 1'b0;
  logic       TXRDY, RXRDY;
  logic [7:0] tx_data;
  logic       tx_valid, tx_ready;
  logic [7:0] rx_data;
  logic       rx_valid, rx_ready;
  logic       cfg_done, err_slv, err_clr;

  always #5 PCLK = ~PCLK;

  uart_apb_ctrl #(
    .BAUD_VALUE(13'h1A5),
    .MODE      (3'b011),
    .GUARD     (GUARD_P)
  ) dut (
    .PCLK    (PCLK),
    .PRESETN (PRESETN),
    .PADDR   (PADDR),
    .PSEL    (PSEL),
    .PENABLE (PENABLE),
    .PWRITE  (PWRITE),
    .PWDATA  (PWDATA),
    .PRDATA  (PRDATA),
    .PREADY  (PREADY),
    .PSLVERR (PSLVERR),
    .TXRDY   (TXRDY),
    .RXRDY   (RXRDY),
    .tx_data (tx_data),
    .tx_valid(tx_valid),
    .tx_ready(tx_ready),
    .rx_data (rx_data),
    .rx_valid(rx_valid),
    .rx_ready(rx_ready),
    .cfg_done(cfg_done),
    .err_slv (err_slv),
    .err_clr (err_clr)
  );

  typedef struct {
    logic [4:0] addr;
    logic       wr;
    logic [7:0] wdata;
    logic [7:0] rdata;
    logic       err;
    int         cyc;
    int         acc;
  } xfer_t;

  xfer_t      xfers[$];
  int         checks = 0;
  int         errors = 0;
  int         cyc = 0;
  int         protoErrs = 0;
  int         accCycles = 0;
  int         gap = 100;
  int         waitCfg = 0;
  logic       errCfg = 1'b0;
  logic       randMode = 1'b0;
  logic [7:0] rdataCfg = 8'h00;
  logic       prevPsel = 1'b0;
  logic       prevSetup = 1'b0;
  logic       prevWrite = 1'b0;
  logic [4:0] prevAddr = 5'h00;
  logic [7:0] prevWdata = 8'h00;

  // Cycle index: value seen at a falling edge equals the number of rising edges so far.
  always @(posedge PCLK) cyc <= cyc + 1;

  // APB completer and bus monitor: answers accesses after waitCfg wait states,
  // logs completed transfers and counts protocol violations.
  always @(negedge PCLK) begin
    if (PSEL && PENABLE) begin
      PREADY  = (accCycles >= waitCfg);
      PSLVERR = PREADY && errCfg;
      PRDATA  = rdataCfg;
      if (!prevPsel) protoErrs++;
      if (PADDR !== prevAddr || PWRITE !== prevWrite || PWDATA !== prevWdata) protoErrs++;
      accCycles++;
      if (PREADY) begin
        xfers.push_back('{PADDR, PWRITE, PWDATA, PRDATA, PSLVERR, cyc + 1, accCycles});
        gap = 0;
      end
    end else begin
      PREADY    = 1'b0;
      PSLVERR   = 1'b0;
      accCycles = 0;
      if (PSEL) begin
        if (prevPsel) protoErrs++;
        if (gap < GUARD_P + 1) protoErrs++;
        if (!PWRITE && rx_valid) protoErrs++;
        if (randMode) begin
          rdataCfg = 8'($urandom);
          waitCfg  = $urandom_range(0, 2);
        end
      end else begin
        gap++;
      end
    end
    if (prevSetup && !(PSEL && PENABLE)) protoErrs++;
    if (tx_ready && PSEL) protoErrs++;
    prevPsel  = PSEL;
    prevSetup = PSEL && !PENABLE;
    prevAddr  = PADDR;
    prevWrite = PWRITE;
    prevWdata = PWDATA;
  end

  task automatic test_reset();
    PRESETN  = 1'b0;
    tx_data  = 8'h00;
    tx_valid = 1'b1;
    TXRDY    = 1'b1;
    RXRDY    = 1'b0;
    rx_ready = 1'b0;
    err_clr  = 1'b0;
    repeat (3) @(negedge PCLK);
    #1;
    checks++;
    if ({PSEL, PENABLE, PWRITE} !== 3'b000) begin
      errors++; $display("[TB] FAIL reset_ctrl got %b want 000", {PSEL, PENABLE, PWRITE});
    end
    checks++;
    if (PADDR !== 5'h00 || PWDATA !== 8'h00) begin
      errors++; $display("[TB] FAIL reset_addr_data got %h/%h want 00/00", PADDR, PWDATA);
    end
    checks++;
    if (tx_ready !== 1'b0) begin
      errors++; $display("[TB] FAIL reset_tx_ready got %b want 0", tx_ready);
    end
    checks++;
    if ({rx_valid, cfg_done, err_slv} !== 3'b000 || rx_data !== 8'h00) begin
      errors++; $display("[TB] FAIL reset_status got %b data %h want 000 data 00",
                         {rx_valid, cfg_done, err_slv}, rx_data);
    end
  endtask

  task automatic test_init();
    int preTx = 0;
    int cfgCyc = -1;
    xfers.delete();
    @(negedge PCLK);
    PRESETN = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge PCLK);
      #1;
      if (tx_ready) preTx++;
      if (cfg_done) begin
        cfgCyc = cyc;
        break;
      end
    end
    tx_valid = 1'b0;
    TXRDY    = 1'b0;
    checks++;
    if (cfgCyc < 0) begin
      errors++; $display("[TB] FAIL init_cfg_done timeout got 0 want 1");
    end
    checks++;
    if (xfers.size() !== 2) begin
      errors++; $display("[TB] FAIL init_count got %0d want 2", xfers.size());
    end else begin
      checks++;
      if ({xfers[0].addr, xfers[0].wr, xfers[0].wdata} !== {5'h08, 1'b1, 8'hA5}) begin
        errors++; $display("[TB] FAIL init_ctrl1 got a=%h w=%b d=%h want a=08 w=1 d=a5",
                           xfers[0].addr, xfers[0].wr, xfers[0].wdata);
      end
      checks++;
      if ({xfers[1].addr, xfers[1].wr, xfers[1].wdata} !== {5'h0C, 1'b1, 8'h0B}) begin
        errors++; $display("[TB] FAIL init_ctrl2 got a=%h w=%b d=%h want a=0c w=1 d=0b",
                           xfers[1].addr, xfers[1].wr, xfers[1].wdata);
      end
      checks++;
      if (cfgCyc !== xfers[1].cyc) begin
        errors++; $display("[TB] FAIL init_cfg_timing got %0d want %0d", cfgCyc, xfers[1].cyc);
      end
    end
    checks++;
    if (preTx !== 0) begin
      errors++; $display("[TB] FAIL init_no_tx got %0d want 0", preTx);
    end
    repeat (4) @(negedge PCLK);
    checks++;
    if (cfg_done !== 1'b1) begin
      errors++; $display("[TB] FAIL init_cfg_sticky got %b want 1", cfg_done);
    end
  endtask

  task automatic test_tx_latency();
    xfers.delete();
    @(negedge PCLK);
    tx_data = 8'h55; tx_valid = 1'b1; TXRDY = 1'b1;
    #1;
    checks++;
    if (tx_ready !== 1'b1) begin
      errors++; $display("[TB] FAIL tx_ready_N got %b want 1", tx_ready);
    end
    @(negedge PCLK);
    tx_valid = 1'b0;
    #1;
    checks++;
    if ({PSEL, PENABLE, PWRITE, PADDR, PWDATA, tx_ready} !== {3'b101, 5'h00, 8'h55, 1'b0}) begin
      errors++; $display("[TB] FAIL tx_setup_N1 got %b %h %h %b want 101 00 55 0",
                         {PSEL, PENABLE, PWRITE}, PADDR, PWDATA, tx_ready);
    end
    @(negedge PCLK);
    checks++;
    if ({PSEL, PENABLE, PWRITE, PADDR, PWDATA} !== {3'b111, 5'h00, 8'h55}) begin
      errors++; $display("[TB] FAIL tx_access_N2 got %b %h %h want 111 00 55",
                         {PSEL, PENABLE, PWRITE}, PADDR, PWDATA);
    end
    @(negedge PCLK);
    tx_data = 8'hAA; tx_valid = 1'b1;
    #1;
    checks++;
    if ({PSEL, tx_ready} !== 2'b00) begin
      errors++; $display("[TB] FAIL tx_hold_N3 got %b want 00", {PSEL, tx_ready});
    end
    @(negedge PCLK);
    #1;
    checks++;
    if ({PSEL, tx_ready} !== 2'b00) begin
      errors++; $display("[TB] FAIL tx_hold_N4 got %b want 00", {PSEL, tx_ready});
    end
    @(negedge PCLK);
    #1;
    checks++;
    if (tx_ready !== 1'b1) begin
      errors++; $display("[TB] FAIL tx_idle_N5 got %b want 1", tx_ready);
    end
    @(negedge PCLK);
    tx_valid = 1'b0; TXRDY = 1'b0;
    repeat (6) @(negedge PCLK);
    checks++;
    if (xfers.size() !== 2) begin
      errors++; $display("[TB] FAIL tx_count got %0d want 2", xfers.size());
    end else begin
      checks++;
      if ({xfers[1].addr, xfers[1].wr, xfers[1].wdata} !== {5'h00, 1'b1, 8'hAA}) begin
        errors++; $display("[TB] FAIL tx_second got a=%h w=%b d=%h want a=00 w=1 d=aa",
                           xfers[1].addr, xfers[1].wr, xfers[1].wdata);
      end
    end
  endtask

  task automatic test_rx_priority();
    int gotCyc = -1;
    logic got = 1'b0;
    xfers.delete();
    rdataCfg = 8'h3C;
    @(negedge PCLK);
    RXRDY = 1'b1; tx_valid = 1'b1; TXRDY = 1'b1; tx_data = 8'h77;
    #1;
    checks++;
    if (tx_ready !== 1'b0) begin
      errors++; $display("[TB] FAIL prio_tx_blocked got %b want 0", tx_ready);
    end
    @(negedge PCLK);
    RXRDY = 1'b0;
    checks++;
    if ({PSEL, PENABLE, PWRITE, PADDR} !== {3'b100, 5'h04}) begin
      errors++; $display("[TB] FAIL prio_rx_setup got %b %h want 100 04",
                         {PSEL, PENABLE, PWRITE}, PADDR);
    end
    for (int i = 0; i < 20; i++) begin
      @(negedge PCLK);
      #1;
      if (rx_valid) begin gotCyc = cyc; break; end
    end
    checks++;
    if (gotCyc < 0 || rx_data !== 8'h3C) begin
      errors++; $display("[TB] FAIL prio_rx_data got v=%b d=%h want v=1 d=3c", rx_valid, rx_data);
    end
    checks++;
    if (xfers.size() < 1 || gotCyc !== xfers[0].cyc) begin
      errors++; $display("[TB] FAIL prio_rx_timing got %0d want completion+1", gotCyc);
    end
    for (int i = 0; i < 20; i++) begin
      @(negedge PCLK);
      #1;
      if (tx_ready) begin got = 1'b1; break; end
    end
    @(negedge PCLK);
    tx_valid = 1'b0; TXRDY = 1'b0;
    checks++;
    if (!got) begin
      errors++; $display("[TB] FAIL prio_tx_follow timeout got 0 want 1");
    end
    repeat (6) @(negedge PCLK);
    checks++;
    if (xfers.size() !== 2 || xfers[1].addr !== 5'h00 || xfers[1].wdata !== 8'h77) begin
      errors++; $display("[TB] FAIL prio_tx_xfer got n=%0d want 2 with write 00=77", xfers.size());
    end
    checks++;
    if (rx_valid !== 1'b1) begin
      errors++; $display("[TB] FAIL prio_rx_held got %b want 1", rx_valid);
    end
    rx_ready = 1'b1;
    @(negedge PCLK);
    rx_ready = 1'b0;
    checks++;
    if (rx_valid !== 1'b0) begin
      errors++; $display("[TB] FAIL prio_rx_clear got %b want 0", rx_valid);
    end
  endtask

  task automatic test_backpressure();
    int n;
    logic got = 1'b0;
    rdataCfg = 8'h11;
    @(negedge PCLK);
    RXRDY = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge PCLK);
      #1;
      if (rx_valid) begin got = 1'b1; break; end
    end
    rdataCfg = 8'h22;
    n = xfers.size();
    repeat (10) @(negedge PCLK);
    checks++;
    if (!got || xfers.size() !== n || PSEL !== 1'b0) begin
      errors++; $display("[TB] FAIL bp_no_read got got=%b n=%0d psel=%b want 1 %0d 0",
                         got, xfers.size(), PSEL, n);
    end
    checks++;
    if (rx_valid !== 1'b1 || rx_data !== 8'h11) begin
      errors++; $display("[TB] FAIL bp_held got v=%b d=%h want v=1 d=11", rx_valid, rx_data);
    end
    rx_ready = 1'b1;
    @(negedge PCLK);
    rx_ready = 1'b0;
    checks++;
    if (rx_valid !== 1'b0) begin
      errors++; $display("[TB] FAIL bp_release got %b want 0", rx_valid);
    end
    got = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge PCLK);
      #1;
      if (rx_valid) begin got = 1'b1; break; end
    end
    checks++;
    if (!got || rx_data !== 8'h22 || xfers.size() !== n + 1) begin
      errors++; $display("[TB] FAIL bp_next_read got v=%b d=%h n=%0d want 1 22 %0d",
                         got, rx_data, xfers.size(), n + 1);
    end
    RXRDY = 1'b0;
    rx_ready = 1'b1;
    @(negedge PCLK);
    rx_ready = 1'b0;
  endtask

  task automatic test_wait_err();
    logic got = 1'b0;
    xfers.delete();
    waitCfg = 3; errCfg = 1'b1;
    @(negedge PCLK);
    tx_data = 8'h5A; tx_valid = 1'b1; TXRDY = 1'b1;
    for (int i = 0; i < 30; i++) begin
      if (xfers.size() > 0) begin got = 1'b1; break; end
      @(negedge PCLK);
      #1;
      if (PSEL) begin tx_valid = 1'b0; TXRDY = 1'b0; end
    end
    checks++;
    if (!got || err_slv !== 1'b0) begin
      errors++; $display("[TB] FAIL werr_pending got done=%b err=%b want 1 0", got, err_slv);
    end
    @(negedge PCLK);
    checks++;
    if (err_slv !== 1'b1) begin
      errors++; $display("[TB] FAIL werr_set got %b want 1", err_slv);
    end
    checks++;
    if (xfers.size() < 1 || xfers[0].acc !== 4 || xfers[0].wdata !== 8'h5A || xfers[0].err !== 1'b1) begin
      errors++; $display("[TB] FAIL werr_xfer got n=%0d want 4 access cycles data 5a err 1", xfers.size());
    end
    errCfg = 1'b0; waitCfg = 0;
    repeat (3) @(negedge PCLK);
    checks++;
    if (err_slv !== 1'b1) begin
      errors++; $display("[TB] FAIL werr_sticky got %b want 1", err_slv);
    end
    err_clr = 1'b1;
    @(negedge PCLK);
    err_clr = 1'b0;
    checks++;
    if (err_slv !== 1'b0) begin
      errors++; $display("[TB] FAIL werr_clear got %b want 0", err_slv);
    end
    errCfg = 1'b1; rdataCfg = 8'hC3; err_clr = 1'b1;
    got = 1'b0;
    @(negedge PCLK);
    RXRDY = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge PCLK);
      #1;
      if (rx_valid) begin got = 1'b1; break; end
    end
    checks++;
    if (!got || err_slv !== 1'b1 || rx_data !== 8'hC3) begin
      errors++; $display("[TB] FAIL werr_set_wins got v=%b err=%b d=%h want 1 1 c3",
                         got, err_slv, rx_data);
    end
    @(negedge PCLK);
    checks++;
    if (err_slv !== 1'b0) begin
      errors++; $display("[TB] FAIL werr_clr_after got %b want 0", err_slv);
    end
    err_clr = 1'b0; errCfg = 1'b0; RXRDY = 1'b0;
    rx_ready = 1'b1;
    @(negedge PCLK);
    rx_ready = 1'b0;
    repeat (4) @(negedge PCLK);
  endtask

  task automatic test_reset_mid_access();
    logic got = 1'b0;
    waitCfg = 10;
    @(negedge PCLK);
    tx_data = 8'h99; tx_valid = 1'b1; TXRDY = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge PCLK);
      #1;
      if (PSEL) begin tx_valid = 1'b0; TXRDY = 1'b0; end
      if (PSEL && PENABLE) begin got = 1'b1; break; end
    end
    #2;
    PRESETN = 1'b0;
    #1;
    checks++;
    if (!got || {PSEL, PENABLE, cfg_done} !== 3'b000 || PADDR !== 5'h00 || PWDATA !== 8'h00) begin
      errors++; $display("[TB] FAIL rst_abort got acc=%b %b %h %h want 1 000 00 00",
                         got, {PSEL, PENABLE, cfg_done}, PADDR, PWDATA);
    end
    waitCfg = 0;
    xfers.delete();
    repeat (2) @(negedge PCLK);
    PRESETN = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge PCLK);
      #1;
      if (xfers.size() > 0) begin got = 1'b1; break; end
    end
    checks++;
    if (!got || {xfers[0].addr, xfers[0].wr, xfers[0].wdata} !== {5'h08, 1'b1, 8'hA5}) begin
      errors++; $display("[TB] FAIL rst_reinit got done=%b want first write 08=a5", got);
    end
    got = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge PCLK);
      if (cfg_done) begin got = 1'b1; break; end
    end
    checks++;
    if (!got) begin
      errors++; $display("[TB] FAIL rst_cfg_done timeout got 0 want 1");
    end
    repeat (4) @(negedge PCLK);
  endtask

  task automatic test_back_to_back();
    logic [7:0] txExp[$];
    logic [7:0] rxGot[$];
    logic [7:0] txSeen[$];
    logic [7:0] rxSeen[$];
    int bad = 0;
    int mis = 0;
    xfers.delete();
    randMode = 1'b1;
    for (int i = 0; i < 400; i++) begin
      @(negedge PCLK);
      tx_valid = ($urandom_range(0, 2) != 0);
      tx_data  = 8'($urandom);
      TXRDY    = ($urandom_range(0, 3) != 0);
      RXRDY    = ($urandom_range(0, 1) != 0);
      rx_ready = ($urandom_range(0, 1) != 0);
      #1;
      if (tx_ready) txExp.push_back(tx_data);
      if (rx_valid && rx_ready) rxGot.push_back(rx_data);
    end
    @(negedge PCLK);
    tx_valid = 1'b0; TXRDY = 1'b0; RXRDY = 1'b0; rx_ready = 1'b1;
    for (int i = 0; i < 30; i++) begin
      #1;
      if (rx_valid && rx_ready) rxGot.push_back(rx_data);
      @(negedge PCLK);
    end
    rx_ready = 1'b0;
    randMode = 1'b0;
    waitCfg  = 0;
    foreach (xfers[k]) begin
      if (xfers[k].addr == 5'h00 && xfers[k].wr) txSeen.push_back(xfers[k].wdata);
      else if (xfers[k].addr == 5'h04 && !xfers[k].wr) rxSeen.push_back(xfers[k].rdata);
      else bad++;
    end
    checks++;
    if (bad !== 0 || txExp.size() == 0 || rxSeen.size() == 0) begin
      errors++; $display("[TB] FAIL b2b_traffic got bad=%0d tx=%0d rx=%0d want 0 >0 >0",
                         bad, txExp.size(), rxSeen.size());
    end
    checks++;
    if (txSeen.size() !== txExp.size()) begin
      errors++; $display("[TB] FAIL b2b_tx_count got %0d want %0d", txSeen.size(), txExp.size());
    end else begin
      foreach (txExp[k]) if (txSeen[k] !== txExp[k]) mis++;
      checks++;
      if (mis !== 0) begin
        errors++; $display("[TB] FAIL b2b_tx_data got %0d bad bytes want 0", mis);
      end
    end
    mis = 0;
    checks++;
    if (rxGot.size() !== rxSeen.size()) begin
      errors++; $display("[TB] FAIL b2b_rx_count got %0d want %0d", rxGot.size(), rxSeen.size());
    end else begin
      foreach (rxSeen[k]) if (rxGot[k] !== rxSeen[k]) mis++;
      checks++;
      if (mis !== 0) begin
        errors++; $display("[TB] FAIL b2b_rx_data got %0d bad bytes want 0", mis);
      end
    end
  endtask

  task automatic test_protocol();
    checks++;
    if (protoErrs !== 0) begin
      errors++; $display("[TB] FAIL apb_protocol got %0d violations want 0", protoErrs);
    end
    checks++;
    if (cfg_done !== 1'b1) begin
      errors++; $display("[TB] FAIL final_cfg_done got %b want 1", cfg_done);
    end
  endtask

  initial begin
    $display("[TB] start");
    test_reset();
    test_init();
    test_tx_latency();
    test_rx_priority();
    test_backpressure();
    test_wait_err();
    test_reset_mid_access();
    test_back_to_back();
    test_protocol();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_apb_ctrl.md
UART_APB_CTRL -- requirements
Module: uart_apb_ctrl

Interface
REQ-001 SHALL have parameter BAUD_VALUE, default 1: 13-bit baud divisor written at init.
REQ-002 SHALL have parameter MODE, default 3'b001: {parity_odd, parity_en, bit8} written at init.
REQ-003 SHALL have parameter GUARD, default 2: idle cycles after each APB access, range 1..7.
REQ-004 SHALL have one clock and an asynchronous active-low reset, as below.
REQ-005 PCLK  in  1  sole clock; all logic rising-edge.
REQ-006 PRESETN  in  1  asynchronous active-low reset.
REQ-007 PADDR  out  5  APB master address to UART core.
REQ-008 PSEL  out  1  APB select.
REQ-009 PENABLE  out  1  APB enable.
REQ-010 PWRITE  out  1  APB write (1) / read (0).
REQ-011 PWDATA  out  8  APB write data.
REQ-012 PRDATA  in  8  APB read data.
REQ-013 PREADY  in  1  APB completer ready.
REQ-014 PSLVERR  in  1  APB completer error.
REQ-015 TXRDY  in  1  UART core can accept a TX byte.
REQ-016 RXRDY  in  1  UART core holds a received byte.
REQ-017 tx_data  in  8  byte to send.
REQ-018 tx_valid  in  1  tx_data valid.
REQ-019 tx_ready  out  1  one-cycle pulse: tx_data accepted this cycle.
REQ-020 rx_data  out  8  received byte.
REQ-021 rx_valid  out  1  rx_data valid, held until rx_ready.
REQ-022 rx_ready  in  1  consumer accepts rx_data.
REQ-023 cfg_done  out  1  initialisation writes complete.
REQ-024 err_slv  out  1  sticky: some access completed with PSLVERR=1.
REQ-025 err_clr  in  1  clears err_slv.

Function
REQ-026 FSM states SHALL be INIT1, INIT2, IDLE, SETUP, ACCESS, HOLD; register map: 0x00 TX data, 0x04 RX data, 0x08 CTRL1, 0x0C CTRL2.
REQ-027 INIT1 SHALL write CTRL1 = BAUD_VALUE[7:0]; INIT2 SHALL write CTRL2 = {BAUD_VALUE[12:8], MODE}; each via SETUP/ACCESS/HOLD.
REQ-028 cfg_done SHALL rise the cycle after the INIT2 access completes and stay 1 until reset; no TX/RX access before cfg_done.
REQ-029 SETUP: PSEL=1, PENABLE=0 for exactly one cycle; ACCESS: PSEL=1, PENABLE=1 until PREADY=1; PADDR/PWRITE/PWDATA stable from SETUP through completion.
REQ-030 Outside SETUP/ACCESS, PSEL=PENABLE=0; PADDR, PWRITE, PWDATA hold last value.
REQ-031 HOLD SHALL last exactly GUARD cycles, then IDLE, so TXRDY/RXRDY reflect the completed access.
REQ-032 IDLE arbitration, evaluated each cycle: RX read (RXRDY=1 and rx_valid=0) wins over TX write (tx_valid=1 and TXRDY=1); otherwise stay IDLE.
REQ-033 On TX win: tx_ready=1 that cycle, tx_data captured to PWDATA, PADDR=0x00, PWRITE=1, next state SETUP.
REQ-034 On RX win: PADDR=0x04, PWRITE=0, next SETUP; at completion PRDATA captured to rx_data and rx_valid=1 next cycle.
REQ-035 rx_valid SHALL clear the cycle after rx_valid=1 and rx_ready=1; no new RX read while rx_valid=1 (backpressure leaves byte in core).
REQ-036 TX latency: tx_ready at cycle N; SETUP N+1; ACCESS N+2 (PREADY=1); HOLD N+3..N+2+GUARD; IDLE N+3+GUARD.
REQ-037 PSLVERR=1 at completion SHALL set err_slv; read data still captured; err_clr=1 clears it; set wins if simultaneous.
REQ-038 tx_ready SHALL be 0 in every state except the IDLE TX-win cycle.

Reset
REQ-039 While PRESETN=0: state INIT1, PSEL=PENABLE=PWRITE=0, PADDR=0, PWDATA=0, tx_ready=0, rx_data=0, rx_valid=0, cfg_done=0, err_slv=0.
REQ-040 Reset mid-access SHALL abort immediately; after release, initialisation restarts at INIT1.

Verification
REQ-041 Reset release, BAUD_VALUE=13'h1A5, MODE=3'b011, PREADY=1 -> write 0x08=0xA5, then 0x0C=0x0B; cfg_done=1 after second completion.
REQ-042 tx_data=0x55, tx_valid=1, TXRDY=1, GUARD=2 -> tx_ready pulse N, SETUP N+1, ACCESS N+2 PADDR=0x00 PWDATA=0x55, IDLE N+5.
REQ-043 RXRDY=1, tx_valid=1, TXRDY=1 same cycle -> read 0x04 first; PRDATA=0x3C gives rx_data=0x3C, rx_valid=1; TX follows.
REQ-044 rx_valid=1, rx_ready=0, RXRDY=1 -> no read issued; rx_ready=1 one cycle -> rx_valid=0, read issued.
REQ-045 PREADY=0 for 3 ACCESS cycles, PSLVERR=1 at completion -> signals stable 4 ACCESS cycles, err_slv=1; err_clr -> 0.
REQ-046 PRESETN low during ACCESS -> PSEL=0 immediately; after release, INIT1 write to 0x08 reissued.
